data_mem_responder: RTL and testbench

// - Responder end of the memory-stage load/store interface. It takes the access request the memory stage

---
 rtl/mem_if_pkg.sv | 22 ++
 rtl/sp_ram.sv | 28 ++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 tb/tb_data_mem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// mem_if_pkg : shared types and helpers for the data-memory responder
// Revision   : 1.0
// ============================================================================
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int OFFSET_W   = $clog2(WORD_BYTES);

    function automatic logic is_aligned(input logic [OFFSET_W-1:0] addr_lsb);
        return (addr_lsb == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram.sv
`default_nettype none
// ============================================================================
// sp_ram   : single-port synchronous word RAM with registered read data
// Revision : 1.0
// ============================================================================
module sp_ram #(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // No reset: RAM contents survive rst by design.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder : memory-stage load/store responder with fixed latency
// Revision           : 1.0
// ============================================================================
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_w_en,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              err_misalign,
    output logic              stall
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    mem_state_t       state, state_nxt;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      wdata_q;
    logic             w_en_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_hold;
    logic             accept;
    logic             enter_resp;
    logic [IDX_W+1:0] eff_addr;
    logic [31:0]      eff_wdata;
    logic             eff_w_en;
    logic             ram_we;
    logic [31:0]      ram_rdata;
    logic             misaligned;

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY==1 the commit edge is also the acceptance edge, so the
    // RAM must see the live request rather than the latched copy.
    always_comb begin
        eff_addr  = addr_q;
        eff_wdata = wdata_q;
        eff_w_en  = w_en_q;
        if (state == IDLE) begin
            eff_addr  = req_addr[IDX_W+1:0];
            eff_wdata = req_wdata;
            eff_w_en  = req_w_en;
        end
    end

    assign ram_we = enter_resp && eff_w_en && is_aligned(eff_addr[1:0]) && !rst;

    sp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (eff_addr[IDX_W+1:2]),
        .wdata (eff_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            w_en_q     <= 1'b0;
            rdata_hold <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= req_addr[IDX_W+1:0];
                wdata_q <= req_wdata;
                w_en_q  <= req_w_en;
                cnt     <= CNT_INIT;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == RESP) begin
                rdata_hold <= resp_rdata;
            end
        end
    end

    assign misaligned   = !is_aligned(addr_q[1:0]);
    assign resp_valid   = (state == RESP);
    assign err_misalign = resp_valid && misaligned;
    assign req_ready    = (state == IDLE);
    assign stall        = ((state == IDLE) && req_valid) || (state == WAIT);

    always_comb begin
        resp_rdata = rdata_hold;
        if (resp_valid && !w_en_q) begin
            resp_rdata = misaligned ? 32'h0 : ram_rdata;
        end
    end

    // Address bits above the word index are intentionally ignored (wrap-around).
    if (ADDR_W > IDX_W + 2) begin : g_unused_addr
        logic unused_upper;
        assign unused_upper = ^req_addr[ADDR_W-1:IDX_W+2];
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_data_mem_responder : randomized self-checking bench against a word-array model
// Revision              : 1.0
// ============================================================================
module tb_data_mem_responder;

    localparam int LATENCY = 3;
    localparam int DEPTH   = 256;
    localparam int ADDR_W  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_w_en;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err_misalign;
    logic        stall;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_last;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LATENCY),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_w_en     (req_w_en),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .err_misalign (err_misalign),
        .stall        (stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // One full transaction. b2b=1 means the call starts at the negedge of the
    // previous response cycle, so the request is presented during RESP.
    task automatic txn(input bit w, input logic [31:0] addr, input logic [31:0] wd, input bit b2b);
        int          n;
        bit          aligned;
        logic [31:0] exp_rd;
        aligned = (addr[1:0] == 2'b00);
        if (!b2b) begin
            @(negedge clk);
            check_eq("idle_valid", resp_valid, 0);
            check_eq("idle_ready", req_ready, 1);
            check_eq("idle_stall", stall, 0);
            check_eq("hold_rdata", resp_rdata, model_last);
        end
        req_valid = 1'b1;
        req_w_en  = w;
        req_addr  = addr;
        req_wdata = wd;
        if (b2b) begin
            #1 check_eq("b2b_resp_stall", stall, 0);
            @(negedge clk);
            check_eq("b2b_ready", req_ready, 1);
        end
        #1 check_eq("req_stall", stall, 1);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!resp_valid) begin
                check_eq("wait_stall", stall, 1);
                check_eq("wait_ready", req_ready, 0);
                req_valid = 1'($urandom);
                req_w_en  = 1'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
        end while (!resp_valid && n < 16);
        check_eq("latency", n, LATENCY);
        check_eq("resp_valid", resp_valid, 1);
        check_eq("resp_ready", req_ready, 0);
        check_eq("resp_stall", stall, 0);
        check_eq("err_misalign", err_misalign, !aligned);
        if (w)            exp_rd = model_last;
        else if (aligned) exp_rd = model_mem[widx(addr)];
        else              exp_rd = 32'h0;
        check_eq(w ? "store_rdata" : "load_rdata", resp_rdata, exp_rd);
        if (w && aligned) model_mem[widx(addr)] = wd;
        if (!w)           model_last = exp_rd;
        req_valid = 1'b0;
    endtask

    // Store accepted, then reset on the edge that would have committed it.
    task automatic reset_in_wait(input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_w_en  = 1'b1;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (LATENCY - 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_valid", resp_valid, 0);
        check_eq("rst_rdata", resp_rdata, 0);
        check_eq("rst_err", err_misalign, 0);
        check_eq("rst_stall", stall, 0);
        rst = 1'b0;
        model_last = 32'h0;
    endtask

    initial begin
        logic [31:0] a;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_w_en  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        model_last = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("reset_ready", req_ready, 1);
        check_eq("reset_valid", resp_valid, 0);
        check_eq("reset_rdata", resp_rdata, 0);
        check_eq("reset_err", err_misalign, 0);
        check_eq("reset_stall", stall, 0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            a = ($urandom & ~32'h3FF) | (32'(i) << 2);
            txn(1'b1, a, $urandom, (i > 0) && ($urandom_range(0, 1) == 1));
        end

        txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 1'b0);
        check_eq("deadbeef_load", resp_rdata, 32'hDEADBEEF);

        txn(1'b1, 32'h12, 32'h12345678, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 1'b0);
        check_eq("misalign_no_write", resp_rdata, 32'hDEADBEEF);

        txn(1'b1, 32'h0, 32'h1, 1'b0);
        txn(1'b1, 32'h400, 32'h2, 1'b0);
        txn(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("wrap_load", resp_rdata, 32'h2);

        reset_in_wait(32'h20, 32'h55);
        txn(1'b0, 32'h20, 32'h0, 1'b0);

        txn(1'b0, 32'h10, 32'h0, 1'b0);
        txn(1'b1, 32'h30, 32'hCAFEF00D, 1'b1);
        txn(1'b0, 32'h30, 32'h0, 1'b1);
        check_eq("b2b_raw", resp_rdata, 32'hCAFEF00D);

        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1) a = (a & ~32'h3FC) | (32'($urandom_range(0, 7)) << 2);
            txn(1'($urandom), a, $urandom, $urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
